// File: rtl/mod_cnt_pkg.sv
// Shared direction encodings and the modulo step function for the mod-N up/down counter.
// Step is computed on a 32-bit path, wider than any legal counter, so +1 never overflows.
package mod_cnt_pkg;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  typedef struct packed {
    logic        wrap;
    logic [31:0] value;
  } step_t;

  function automatic step_t next_count(input logic [31:0] count,
                                       input logic        up,
                                       input logic [31:0] modulus);
    step_t s;
    s.wrap  = 1'b0;
    s.value = count;
    if (up == DIR_UP) begin
      if (count == modulus - 32'd1) begin
        s.value = '0;
        s.wrap  = 1'b1;
      end else begin
        s.value = count + 32'd1;
      end
    end else if (up == DIR_DOWN) begin
      if (count == '0) begin
        s.value = modulus - 32'd1;
        s.wrap  = 1'b1;
      end else begin
        s.value = count - 32'd1;
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/sync_t_ff.sv
// Positive-edge toggle flop with asynchronous active-high clear; one per counter bit.
// Latency 1 clock from t to q; no flow control.
module sync_t_ff (
  input  logic clk,
  input  logic reset,
  input  logic t,
  output logic q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q ^ t;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_q <= 1'b0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/mod_n_updown_counter.sv
// Synchronous modulo-N up/down counter with load, enable, tc/wrap/load_err; 1-clock latency, no backpressure.
// Define MOD_N_CNT_SATURATE_EN to hold at the range ends instead of wrapping (wrap then stays 0).
module mod_n_updown_counter
  import mod_cnt_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  localparam logic [31:0] MOD_V = 32'(MODULUS);

  if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
    $error("mod_n_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_t;
  logic             wrap_q, wrap_d;
  logic             load_err_q, load_err_d;
  step_t            step;

  always_comb begin
    step       = next_count(32'(count_q), up, MOD_V);
    count_d    = count_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (32'(load_val) < MOD_V) begin
        count_d = load_val;
      end else begin
        count_d    = '0;
        load_err_d = 1'b1;
      end
    end else if (en) begin
`ifdef MOD_N_CNT_SATURATE_EN
      if (!step.wrap) count_d = WIDTH'(step.value);
`else
      count_d = WIDTH'(step.value);
      wrap_d  = step.wrap;
`endif
    end
  end

  // Each bit toggles exactly when the target differs, so all bits move on one edge.
  assign count_t = count_d ^ count_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sync_t_ff u_tff (
      .clk   (clk),
      .reset (reset),
      .t     (count_t[i]),
      .q     (count_q[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign tc       = (up == DIR_UP) ? (32'(count_q) == MOD_V - 32'd1) : (count_q == '0);
  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule
